ipid_gpio_collector: RTL and testbench

IPID_GPIO_COLLECTOR -- requirements
Module: ipid_gpio_collector

---
 rtl/ipid_gpio_collector_if.sv | 25 ++
 rtl/ipid_gpio_collector.sv | 178 +++++++++++++++++
 tb/tb_ipid_gpio_collector.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipid_gpio_collector_if.sv
// Host/store bus of the IP ID collector.
// master: the collector (samples the GPIO beats, drives trigger/address and the store port).
// slave : the host and storage side.
`timescale 1ns/1ps
interface ipid_gpio_collector_if #(
    parameter int WORDS_PER_IP = 16
);
    logic                         gpio_valid;
    logic [15:0]                  gpio_data;
    logic                         ipid_trigger;
    logic [3:0]                   ipid_addr;
    logic                         ipid_wr_en;
    logic [3:0]                   ipid_wr_addr;
    logic [WORDS_PER_IP*16-1:0]   ipid_wr_data;

    modport master (
        input  gpio_valid, gpio_data,
        output ipid_trigger, ipid_addr, ipid_wr_en, ipid_wr_addr, ipid_wr_data
    );

    modport slave (
        output gpio_valid, gpio_data,
        input  ipid_trigger, ipid_addr, ipid_wr_en, ipid_wr_addr, ipid_wr_data
    );
endinterface

// File: rtl/ipid_gpio_collector.sv
// IP ID collector: requests NUM_IPS IDs from a host over a GPIO-style strobe/data
// pair, checks each SOF / payload / EOF frame and emits one store strobe per ID.
// Optional feature: define IPID_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
`timescale 1ns/1ps
module ipid_gpio_collector #(
    parameter int          NUM_IPS        = 16,
    parameter int          WORDS_PER_IP   = 16,
    parameter logic [15:0] SOF_WORD       = 16'h7A7A,
    parameter logic [15:0] EOF_WORD       = 16'hB9B9,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   err_code,
    ipid_gpio_collector_if.master        bus
);

    localparam int         ID_W     = WORDS_PER_IP * 16;
    localparam int         BEAT_W   = (WORDS_PER_IP > 1) ? $clog2(WORDS_PER_IP) : 1;
    localparam logic [3:0] LAST_IDX = 4'(NUM_IPS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_IP - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SOF     = 2'b01;
    localparam logic [1:0] ERR_FRAME   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_PAYLOAD, S_EOF, S_STORE, S_RELEASE, S_DONE, S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          err_q, err_d;
    logic [3:0]          index_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [ID_W-1:0]     frame_q;
    logic [ID_W-1:0]     wr_data_q;

    logic launch;     // accepted start: new run from index 0
    logic capture;    // payload beat taken this cycle
    logic latch_id;   // good EOF: publish the assembled ID
    logic advance;    // move to the next IP index
    logic timeout_hit;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state and control decode.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        launch   = 1'b0;
        capture  = 1'b0;
        latch_id = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_TRIG;
                    err_d   = ERR_NONE;
                    launch  = 1'b1;
                end
            end
            S_TRIG: begin
                if (bus.gpio_valid) begin
                    if (bus.gpio_data == SOF_WORD) begin
                        state_d = S_PAYLOAD;
                    end else begin
                        state_d = S_ERR;
                        err_d   = ERR_SOF;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!bus.gpio_valid) begin
                    state_d = S_ERR;
                    err_d   = ERR_FRAME;
                end else begin
                    capture = 1'b1;
                    if (beat_q == LAST_BEAT) state_d = S_EOF;
                end
            end
            S_EOF: begin
                if (bus.gpio_valid && bus.gpio_data == EOF_WORD) begin
                    state_d  = S_STORE;
                    latch_id = 1'b1;
                end else begin
                    state_d = S_ERR;
                    err_d   = ERR_FRAME;
                end
            end
            S_STORE: state_d = S_RELEASE;
            S_RELEASE: begin
                if (!bus.gpio_valid) begin
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_TRIG;
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The watchdog only fires while the host has left us parked in one state.
        if (timeout_hit && state_d == state_q) begin
            state_d = S_ERR;
            err_d   = ERR_TIMEOUT;
        end
    end

`ifdef IPID_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             counting;

    assign counting    = (state_q inside {S_TRIG, S_PAYLOAD, S_EOF, S_RELEASE});
    assign timeout_hit = counting && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in the current waiting state; restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    wait_cnt_q <= '0;
        else if (state_d != state_q) wait_cnt_q <= '0;
        else if (counting)           wait_cnt_q <= wait_cnt_q + 1'b1;
    end
`else
    // Watchdog compiled out: TIMEOUT_CYCLES is a positive count, so this is constant 0.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Run bookkeeping: IP index, beat count and sticky error code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_q <= '0;
            beat_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            err_q <= err_d;
            if (launch)        index_q <= '0;
            else if (advance)  index_q <= index_q + 1'b1;
            if (state_q == S_TRIG) beat_q <= '0;
            else if (capture)      beat_q <= beat_q + 1'b1;
        end
    end

    // Payload assembly (first beat lands in the MSBs) and the held store word.
    // NOTE: the ID buffers are plain flops, not a RAM, so they take the async reset to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q   <= '0;
            wr_data_q <= '0;
        end else begin
            if (capture)  frame_q[ID_W-1-16*int'(beat_q) -: 16] <= bus.gpio_data;
            if (latch_id) wr_data_q <= frame_q;
        end
    end

    // Outputs decode straight from state, so reset clears them in the same cycle.
    assign bus.ipid_trigger = (state_q inside {S_TRIG, S_PAYLOAD, S_EOF, S_STORE});
    assign bus.ipid_addr    = index_q;
    assign bus.ipid_wr_en   = (state_q == S_STORE);
    assign bus.ipid_wr_addr = index_q;
    assign bus.ipid_wr_data = wr_data_q;
    assign busy             = (state_q inside {S_TRIG, S_PAYLOAD, S_EOF, S_STORE, S_RELEASE});
    assign done             = (state_q == S_DONE);
    assign error            = (state_q == S_ERR);
    assign err_code         = err_q;

endmodule

// File: tb/tb_ipid_gpio_collector.sv
// Self-checking bench for ipid_gpio_collector: a host model answers each trigger
// with a frame, and a scoreboard queue holds the store each good frame must produce.
`timescale 1ns/1ps
module tb_ipid_gpio_collector;

    localparam int          NIP  = 16;
    localparam int          WPI  = 16;
    localparam int          W    = WPI * 16;
    localparam logic [15:0] SOF  = 16'h7A7A;
    localparam logic [15:0] EOFW = 16'hB9B9;

    typedef struct packed {
        logic [3:0]   addr;
        logic [W-1:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [1:0] err_code;

    int         n_assert = 0;
    int         n_fail   = 0;
    exp_t       exp_q[$];
    logic [W-1:0] last_id = '0;

    ipid_gpio_collector_if #(.WORDS_PER_IP(WPI)) bus ();

    ipid_gpio_collector #(
        .NUM_IPS(NIP), .WORDS_PER_IP(WPI), .SOF_WORD(SOF), .EOF_WORD(EOFW), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout simulation did not finish within 2 ms");
        $fatal(1, "global timeout");
    end

    // Scoreboard: every store strobe must match the oldest expected ID.
    always @(negedge clk) begin
        if (bus.ipid_wr_en === 1'b1) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL store_unexpected addr=%0d (no store was due)", bus.ipid_wr_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.ipid_wr_addr !== e.addr || bus.ipid_wr_data !== e.data) begin
                    n_fail++;
                    $display("FAIL store_data got addr=%0d data=%h expected addr=%0d data=%h",
                             bus.ipid_wr_addr, bus.ipid_wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_trigger(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.ipid_trigger === 1'b1 && bus.ipid_addr === 4'(idx)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL trigger_wait idx=%0d got trigger=%b addr=%0d", idx, bus.ipid_trigger, bus.ipid_addr);
        end
    endtask

    // Host model: one frame for IP idx. drop_at >= 0 drops valid after that many payload beats.
    task automatic send_ip(input int idx, input logic [15:0] sof, input logic [15:0] eof, input int drop_at);
        logic [W-1:0] id;
        logic [15:0]  word;
        bit           ok;
        bit           good;
        exp_t         e;
        good = (sof == SOF) && (eof == EOFW) && (drop_at < 0);
        wait_trigger(idx, ok);
        if (!ok) return;
        bus.gpio_valid = 1'b1;
        bus.gpio_data  = sof;
        @(negedge clk);
        if (sof != SOF) begin
            bus.gpio_valid = 1'b0;
            return;
        end
        for (int k = 0; k < WPI; k++) begin
            if (k == drop_at) begin
                bus.gpio_valid = 1'b0;
                return;
            end
            word = 16'($urandom);
            id[W-1-16*k -: 16] = word;
            bus.gpio_data = word;
            @(negedge clk);
        end
        if (good) begin
            e.addr = 4'(idx);
            e.data = id;
            exp_q.push_back(e);
            last_id = id;
        end
        bus.gpio_data = eof;
        @(negedge clk);
        bus.gpio_valid = 1'b0;
        bus.gpio_data  = '0;
        if (good) begin
            n_assert++;
            if (bus.ipid_wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL store_latency idx=%0d wr_en=%b expected 1 one cycle after EOF", idx, bus.ipid_wr_en);
            end
            @(negedge clk);
            n_assert++;
            if (bus.ipid_trigger !== 1'b0 || bus.ipid_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL release_trigger idx=%0d trigger=%b wr_en=%b expected 0/0", idx, bus.ipid_trigger, bus.ipid_wr_en);
            end
        end
    endtask

    task automatic check_queue_empty(input string name);
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_stores got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_done(input string name);
        n_assert++;
        if ({done, error, busy, err_code, bus.ipid_trigger} !== 6'b100000) begin
            n_fail++;
            $display("FAIL %s_done got done=%b error=%b busy=%b err_code=%b trigger=%b expected 1/0/0/00/0",
                     name, done, error, busy, err_code, bus.ipid_trigger);
        end
    endtask

    task automatic check_error(input string name, input logic [1:0] code);
        n_assert++;
        if ({error, done, busy, bus.ipid_trigger, bus.ipid_wr_en} !== 5'b10000 || err_code !== code) begin
            n_fail++;
            $display("FAIL %s_error got error=%b done=%b busy=%b trigger=%b wr_en=%b err_code=%b expected 1/0/0/0/0 code=%b",
                     name, error, done, busy, bus.ipid_trigger, bus.ipid_wr_en, err_code, code);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_assert++;
        if ({busy, done, error, err_code, bus.ipid_trigger, bus.ipid_addr, bus.ipid_wr_en, bus.ipid_wr_addr} !== '0
            || bus.ipid_wr_data !== '0) begin
            n_fail++;
            $display("FAIL %s_outputs_zero got busy=%b done=%b error=%b err_code=%b trigger=%b addr=%0d wr_en=%b wr_addr=%0d wr_data=%h",
                     name, busy, done, error, err_code, bus.ipid_trigger, bus.ipid_addr, bus.ipid_wr_en,
                     bus.ipid_wr_addr, bus.ipid_wr_data);
        end
    endtask

    task automatic test_reset();
        #1;
        check_all_zero("reset_asserted");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_released_idle");
    endtask

    task automatic run_full(input string name);
        for (int i = 0; i < NIP; i++) send_ip(i, SOF, EOFW, -1);
        @(negedge clk);
        check_done(name);
        check_queue_empty(name);
        n_assert++;
        if (bus.ipid_wr_data !== last_id) begin
            n_fail++;
            $display("FAIL %s_wr_data_hold got %h expected %h", name, bus.ipid_wr_data, last_id);
        end
    endtask

    task automatic test_nominal();
        pulse_start();
        n_assert++;
        if (busy !== 1'b1 || bus.ipid_trigger !== 1'b1 || bus.ipid_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL nominal_start got busy=%b trigger=%b addr=%0d expected 1/1/0", busy, bus.ipid_trigger, bus.ipid_addr);
        end
        for (int i = 0; i < NIP; i++) begin
            if (i == 5) begin
                pulse_start();
                n_assert++;
                if (bus.ipid_addr !== 4'd5 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_ignored_busy got addr=%0d busy=%b expected 5/1", bus.ipid_addr, busy);
                end
            end
            send_ip(i, SOF, EOFW, -1);
        end
        @(negedge clk);
        check_done("nominal");
        check_queue_empty("nominal");
        n_assert++;
        if (bus.ipid_wr_data !== last_id || bus.ipid_wr_addr !== 4'd15) begin
            n_fail++;
            $display("FAIL nominal_hold got addr=%0d data=%h expected 15 %h", bus.ipid_wr_addr, bus.ipid_wr_data, last_id);
        end
    endtask

    task automatic test_bad_sof();
        pulse_start();
        n_assert++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_done got done=%b busy=%b expected 0/1", done, busy);
        end
        send_ip(0, 16'h1234, EOFW, -1);
        repeat (2) @(negedge clk);
        check_error("bad_sof", 2'b01);
        repeat (3) @(negedge clk);
        check_error("bad_sof_sticky", 2'b01);
        check_queue_empty("bad_sof");
    endtask

    task automatic test_bad_eof();
        pulse_start();
        n_assert++;
        if (err_code !== 2'b00 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears_error got error=%b err_code=%b expected 0/00", error, err_code);
        end
        for (int i = 0; i < 3; i++) send_ip(i, SOF, EOFW, -1);
        send_ip(3, SOF, 16'hB9B8, -1);
        repeat (2) @(negedge clk);
        check_error("bad_eof", 2'b10);
        check_queue_empty("bad_eof");
    endtask

    task automatic test_back_to_back();
        pulse_start();
        send_ip(0, SOF, EOFW, 6);
        repeat (2) @(negedge clk);
        check_error("valid_drop", 2'b10);
        check_queue_empty("valid_drop");
        pulse_start();
        n_assert++;
        if (bus.ipid_addr !== 4'd0 || err_code !== 2'b00 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_after_drop got addr=%0d err_code=%b busy=%b expected 0/00/1",
                     bus.ipid_addr, err_code, busy);
        end
        run_full("rerun");
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        pulse_start();
        for (int i = 0; i < 7; i++) send_ip(i, SOF, EOFW, -1);
        wait_trigger(7, ok);
        bus.gpio_valid = 1'b1;
        bus.gpio_data  = SOF;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.gpio_data = 16'($urandom);
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1 check_all_zero("reset_mid_frame_immediate");
        repeat (3) @(negedge clk);
        check_all_zero("reset_mid_frame_held");
        bus.gpio_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_mid_frame_idle");
        check_queue_empty("reset_mid_frame");
    endtask

    task automatic test_timeout();
        pulse_start();
`ifdef IPID_TIMEOUT_EN
        repeat (1023) @(negedge clk);
        n_assert++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early got error=%b busy=%b expected 0/1 at cycle 1023", error, busy);
        end
        @(negedge clk);
        check_error("timeout", 2'b11);
`else
        repeat (1100) @(negedge clk);
        n_assert++;
        if (error !== 1'b0 || busy !== 1'b1 || bus.ipid_trigger !== 1'b1) begin
            n_fail++;
            $display("FAIL no_watchdog got error=%b busy=%b trigger=%b expected 0/1/1", error, busy, bus.ipid_trigger);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("no_watchdog_reset");
`endif
    endtask

    initial begin
        bus.gpio_valid = 1'b0;
        bus.gpio_data  = '0;
        test_reset();
        test_nominal();
        test_bad_sof();
        test_bad_eof();
        test_back_to_back();
        test_reset_mid_frame();
        test_timeout();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
